// File: rtl/jtag_port_switch.sv
// jtag_port_switch: routes one of NUM_PORTS external JTAG pin sets to a
// single internal TAP. A port change runs a clocked switch sequence: TCK is
// parked low for SETTLE_CYCLES (DRAIN), then RESET_TMS_CYCLES TCK pulses are
// issued with TMS high (RSEQ). This puts the TAP in Test-Logic-Reset before
// the new port takes ownership.
// Optional build macro: JTAG_SWITCH_TRST_EN. When defined, jtag_rst_n is also
// driven low for the whole DRAIN phase, giving a hardware TRST on top of the
// TMS reset burst.
module jtag_port_switch #(
  parameter int NUM_PORTS        = 2,
  parameter int SETTLE_CYCLES    = 8,
  parameter int RESET_TMS_CYCLES = 5,
  localparam int SEL_W = ($clog2(NUM_PORTS) < 1) ? 1 : $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEL_W-1:0]     port_sel,
  input  logic [NUM_PORTS-1:0] port_tck,
  input  logic [NUM_PORTS-1:0] port_tms,
  input  logic [NUM_PORTS-1:0] port_tdi,
  input  logic [NUM_PORTS-1:0] port_trst_n,
  output logic [NUM_PORTS-1:0] port_tdo,
  output logic                 jtag_clk,
  output logic                 jtag_tms,
  output logic                 jtag_tdi,
  output logic                 jtag_rst_n,
  input  logic                 jtag_tdo,
  output logic [SEL_W-1:0]     active_port,
  output logic                 switching,
  output logic                 sel_error,
  output logic [15:0]          switch_count
);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_RSEQ   = 2'd2;

  localparam logic [SEL_W:0] PORT_LIMIT  = (SEL_W + 1)'(NUM_PORTS);
  localparam logic [7:0]     SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [4:0]     RSEQ_LAST   = 5'(2 * RESET_TMS_CYCLES - 1);
  localparam logic [15:0]    COUNT_MAX   = 16'hFFFF;

`ifdef JTAG_SWITCH_TRST_EN
  localparam logic DRAIN_RST_N = 1'b0;
`else
  localparam logic DRAIN_RST_N = 1'b1;
`endif

  logic [1:0]       state;
  logic [SEL_W-1:0] target;
  logic [7:0]       settle_cnt;
  logic [4:0]       rseq_cnt;
  logic             rseq_clk;
  logic             sel_valid;
  logic             sel_new_active;
  logic             sel_new_target;

  assign sel_valid      = ({1'b0, port_sel} < PORT_LIMIT);
  assign sel_new_active = sel_valid && (port_sel != active_port);
  assign sel_new_target = sel_valid && (port_sel != target);
  assign switching      = (state != ST_ACTIVE);

  // Out-of-range selections are never acted on, only remembered until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_error <= 1'b0;
    end else if (!sel_valid) begin
      sel_error <= 1'b1;
    end
  end

  // Switch sequencer: ACTIVE -> DRAIN (TCK parked) -> RSEQ (TMS-high burst).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ACTIVE;
      active_port  <= '0;
      target       <= '0;
      settle_cnt   <= '0;
      rseq_cnt     <= '0;
      rseq_clk     <= 1'b0;
      switch_count <= '0;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (sel_new_active) begin
            target     <= port_sel;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (sel_new_target) begin
            target     <= port_sel;
            settle_cnt <= SETTLE_LOAD;
          end else if (settle_cnt == 8'd0) begin
            state    <= ST_RSEQ;
            rseq_cnt <= '0;
            rseq_clk <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        ST_RSEQ: begin
          if (sel_valid) begin
            target <= port_sel;
          end
          if (rseq_cnt == RSEQ_LAST) begin
            state       <= ST_ACTIVE;
            rseq_clk    <= 1'b0;
            active_port <= target;
            if (switch_count != COUNT_MAX) begin
              switch_count <= switch_count + 16'd1;
            end
          end else begin
            rseq_cnt <= rseq_cnt + 5'd1;
            rseq_clk <= ~rseq_clk;
          end
        end
        default: begin
          state    <= ST_ACTIVE;
          rseq_clk <= 1'b0;
        end
      endcase
    end
  end

  // TAP-side and port-side pin routing; parked levels unless ACTIVE.
  always_comb begin
    jtag_clk   = 1'b0;
    jtag_tms   = 1'b1;
    jtag_tdi   = 1'b0;
    jtag_rst_n = 1'b1;
    port_tdo   = '0;
    case (state)
      ST_ACTIVE: begin
        jtag_clk              = port_tck[active_port];
        jtag_tms              = port_tms[active_port];
        jtag_tdi              = port_tdi[active_port];
        jtag_rst_n            = port_trst_n[active_port];
        port_tdo[active_port] = jtag_tdo;
      end
      ST_DRAIN: begin
        jtag_rst_n = DRAIN_RST_N;
      end
      ST_RSEQ: begin
        jtag_clk = rseq_clk;
      end
      default: begin
        jtag_clk = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_jtag_port_switch.sv
// tb_jtag_port_switch: randomized self-checking bench for jtag_port_switch
// (3 ports, 4 settle cycles, 5 TMS pulses). The reference model describes a
// switch as a countdown of remaining busy cycles and derives every expected
// pin level from the elapsed cycle position inside that window.
module tb_jtag_port_switch;

  localparam int NP     = 3;
  localparam int SETTLE = 4;
  localparam int RTMS   = 5;
  localparam int TOTAL  = SETTLE + 2 * RTMS;

`ifdef JTAG_SWITCH_TRST_EN
  localparam bit TRST_EN = 1'b1;
`else
  localparam bit TRST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    port_sel;
  logic [NP-1:0] port_tck, port_tms, port_tdi, port_trst_n, port_tdo;
  logic          jtag_clk, jtag_tms, jtag_tdi, jtag_rst_n, jtag_tdo;
  logic [1:0]    active_port;
  logic          switching, sel_error;
  logic [15:0]   switch_count;

  int errors = 0;
  int checks = 0;

  jtag_port_switch #(
    .NUM_PORTS(NP),
    .SETTLE_CYCLES(SETTLE),
    .RESET_TMS_CYCLES(RTMS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .port_sel(port_sel),
    .port_tck(port_tck),
    .port_tms(port_tms),
    .port_tdi(port_tdi),
    .port_trst_n(port_trst_n),
    .port_tdo(port_tdo),
    .jtag_clk(jtag_clk),
    .jtag_tms(jtag_tms),
    .jtag_tdi(jtag_tdi),
    .jtag_rst_n(jtag_rst_n),
    .jtag_tdo(jtag_tdo),
    .active_port(active_port),
    .switching(switching),
    .sel_error(sel_error),
    .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  // Reference model: busy window length remaining, owner, pending target.
  int          m_left;
  int          m_elapsed;
  logic [1:0]  m_active, m_target;
  logic        m_err;
  logic [15:0] m_count;

  assign m_elapsed = TOTAL - m_left;

  // Model update on each clock edge from the sampled selection.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   <= 0;
      m_active <= 2'd0;
      m_target <= 2'd0;
      m_err    <= 1'b0;
      m_count  <= 16'd0;
    end else begin
      if (port_sel >= NP) m_err <= 1'b1;
      if (m_left == 0) begin
        if (port_sel < NP && port_sel != m_active) begin
          m_target <= port_sel;
          m_left   <= TOTAL;
        end
      end else if (m_elapsed < SETTLE && port_sel < NP && port_sel != m_target) begin
        m_target <= port_sel;
        m_left   <= TOTAL;
      end else begin
        if (port_sel < NP) m_target <= port_sel;
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_active <= m_target;
          if (m_count != 16'hFFFF) m_count <= m_count + 16'd1;
        end
      end
    end
  end

  logic          e_clk, e_tms, e_tdi, e_rst;
  logic [NP-1:0] e_tdo;

  // Expected pin levels from the model's position in the switch window.
  always_comb begin
    e_clk = 1'b0;
    e_tms = 1'b1;
    e_tdi = 1'b0;
    e_rst = 1'b1;
    e_tdo = '0;
    if (m_left == 0) begin
      e_clk           = port_tck[m_active];
      e_tms           = port_tms[m_active];
      e_tdi           = port_tdi[m_active];
      e_rst           = port_trst_n[m_active];
      e_tdo[m_active] = jtag_tdo;
    end else if (m_elapsed < SETTLE) begin
      e_rst = !TRST_EN;
    end else begin
      e_clk = (((m_elapsed - SETTLE) % 2) == 0);
    end
  end

  logic [26:0] obs_vec, exp_vec;
  assign obs_vec = {jtag_clk, jtag_tms, jtag_tdi, jtag_rst_n, port_tdo,
                    active_port, switching, sel_error, switch_count};
  assign exp_vec = {e_clk, e_tms, e_tdi, e_rst, e_tdo,
                    m_active, (m_left != 0), m_err, m_count};

  task automatic drive_random_pins();
    port_tck    = 3'($urandom);
    port_tms    = 3'($urandom);
    port_tdi    = 3'($urandom);
    port_trst_n = 3'($urandom);
    jtag_tdo    = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 drive_random_pins();
    @(negedge clk);
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++;
      $display("[TB] FAIL reset_model t=%0t got=%h exp=%h", $time, obs_vec, exp_vec);
    end
    checks++;
    if ({switching, sel_error, active_port, switch_count} !== 20'd0) begin
      errors++;
      $display("[TB] FAIL reset_values got=%h exp=0", {switching, sel_error, active_port, switch_count});
    end
    checks++;
    if ({jtag_clk, jtag_tms, jtag_tdi} !== {port_tck[0], port_tms[0], port_tdi[0]}) begin
      errors++;
      $display("[TB] FAIL reset_passthru got=%b exp=%b", {jtag_clk, jtag_tms, jtag_tdi},
               {port_tck[0], port_tms[0], port_tdi[0]});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic_switch();
    int sw_cycles = 0;
    int drain_high = 0;
    int pulses = 0;
    int tms_low = 0;
    @(posedge clk);
    #1 port_sel = 2'd1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 drive_random_pins();
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL basic_switch cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (switching) begin
        sw_cycles++;
        if (i < SETTLE && jtag_clk) drain_high++;
        if (i >= SETTLE && jtag_clk) pulses++;
        if (!jtag_tms) tms_low++;
      end
    end
    checks++;
    if (sw_cycles != 14) begin
      errors++;
      $display("[TB] FAIL switch_duration got=%0d exp=14", sw_cycles);
    end
    checks++;
    if ({drain_high, pulses, tms_low} != {32'd0, 32'd5, 32'd0}) begin
      errors++;
      $display("[TB] FAIL tms_burst drain_high=%0d pulses=%0d tms_low=%0d exp=0/5/0",
               drain_high, pulses, tms_low);
    end
    checks++;
    if (active_port !== 2'd1 || switch_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL switch_result got=%0d/%0d exp=1/1", active_port, switch_count);
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 drive_random_pins();
      if (i == 19) jtag_tdo = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL passthrough cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (port_tdo !== 3'b010 || jtag_clk !== port_tck[1]) begin
      errors++;
      $display("[TB] FAIL port1_tdo got=%b exp=010", port_tdo);
    end
  endtask

  task automatic test_reset_mid_switch();
    @(posedge clk);
    #1 port_sel = 2'd2;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1 drive_random_pins();
      if (i == 6) begin
        rst_n    = 1'b0;
        port_sel = 2'd0;
      end
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL mid_reset cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if ({switching, active_port, switch_count} !== 19'd0 || jtag_clk !== port_tck[0]) begin
      errors++;
      $display("[TB] FAIL mid_reset_values got=%h exp=0", {switching, active_port, switch_count});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_sel_error();
    @(posedge clk);
    #1 port_sel = 2'd3;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 drive_random_pins();
      if (i == 4) port_sel = 2'd0;
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL sel_error cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (sel_error !== 1'b1 || switching !== 1'b0 || active_port !== 2'd0) begin
      errors++;
      $display("[TB] FAIL sel_error_sticky got=%b%b%0d exp=100", sel_error, switching, active_port);
    end
  endtask

  task automatic test_restart();
    int sw_cycles = 0;
    @(posedge clk);
    #1 port_sel = 2'd1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1 drive_random_pins();
      if (i == 1) port_sel = 2'd2;
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL restart cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (switching) sw_cycles++;
    end
    checks++;
    if (sw_cycles != 16 || active_port !== 2'd2 || switch_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL restart_result got=%0d/%0d/%0d exp=16/2/1", sw_cycles, active_port, switch_count);
    end
  endtask

  task automatic test_trst();
    int low_drain = 0;
    int low_rseq = 0;
    rst_n = 1'b0;
    port_sel = 2'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    port_sel = 2'd2;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1 drive_random_pins();
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL trst cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (switching && !jtag_rst_n) begin
        if (i < SETTLE) low_drain++;
        else low_rseq++;
      end
    end
    checks++;
    if (low_drain != (TRST_EN ? 4 : 0) || low_rseq != 0) begin
      errors++;
      $display("[TB] FAIL trst_window got=%0d/%0d exp=%0d/0", low_drain, low_rseq, TRST_EN ? 4 : 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1 drive_random_pins();
      if ($urandom_range(0, 15) == 0) port_sel = 2'($urandom_range(0, 3));
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL random cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    port_sel    = 2'd0;
    port_tck    = '0;
    port_tms    = '0;
    port_tdi    = '0;
    port_trst_n = '1;
    jtag_tdo    = 1'b0;
    test_reset();
    test_basic_switch();
    test_passthrough();
    test_reset_mid_switch();
    test_sel_error();
    test_restart();
    test_trst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_port_switch.md
# jtag_port_switch

Parametrised debug-port switch between NUM_PORTS external JTAG/cJTAG-derived pin sets and a single internal TAP. Successor to the fixed two-way JTAG/cJTAG mux. Mode changes are no longer instantaneous: a clocked switch sequence parks TCK low, waits a settle period, then drives a TMS-high clock burst so the TAP is in Test-Logic-Reset before the new port takes over. Sits between the pad/OScan1 front ends and the TAP controller.

## Interface
- NUM_PORTS, default 2: number of selectable ports, 2..8.
- SETTLE_CYCLES, default 8: clk cycles TCK is held low in DRAIN, 1..255.
- RESET_TMS_CYCLES, default 5: TCK pulses with TMS=1 issued in RSEQ, 5..15.
- SEL_W (localparam) = max(1, $clog2(NUM_PORTS)).

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- port_sel  in  SEL_W  requested port, clk-domain
- port_tck  in  NUM_PORTS  per-port TCK
- port_tms  in  NUM_PORTS  per-port TMS
- port_tdi  in  NUM_PORTS  per-port TDI
- port_trst_n  in  NUM_PORTS  per-port TRST (tie 1 for cJTAG ports)
- port_tdo  out  NUM_PORTS  per-port TDO
- jtag_clk, jtag_tms, jtag_tdi, jtag_rst_n  out  1 each  to TAP
- jtag_tdo  in  1  from TAP
- active_port  out  SEL_W  port currently owning the TAP
- switching  out  1  high while state != ACTIVE
- sel_error  out  1  sticky, port_sel >= NUM_PORTS seen
- switch_count  out  16  completed switches, saturating

## Operation
- States: ACTIVE, DRAIN, RSEQ.
- ACTIVE: combinational pass-through of port[active_port] to jtag_clk/tms/tdi/rst_n; port_tdo[active_port]=jtag_tdo, all other port_tdo bits 0.
- ACTIVE -> DRAIN: at a clk edge with valid port_sel != active_port; target <= port_sel; settle counter <= SETTLE_CYCLES-1.
- DRAIN: jtag_clk=0, jtag_tms=1, jtag_tdi=0, all port_tdo=0. Counter decrements; at 0 -> RSEQ, pulse counter <= 0. If a valid port_sel differing from target is sampled during DRAIN: target updated, settle counter reloaded (restart).
- RSEQ: jtag_tms=1, jtag_tdi=0; jtag_clk registered, toggles each clk: high 1 cycle, low 1 cycle, RESET_TMS_CYCLES pulses (2*RESET_TMS_CYCLES cycles). port_sel changes are latched into target but do not abort. At end -> ACTIVE, active_port <= target, switch_count increments (saturate 0xFFFF). If port_sel then differs, next edge re-enters DRAIN.
- port_sel back to active_port during DRAIN: switch still completes (target=active_port), TAP reset anyway.
- port_sel >= NUM_PORTS: ignored in every state; sel_error set, cleared only by rst_n.
- jtag_rst_n outside ACTIVE: 1 (see Configuration).

## Timing
- Reset values: state ACTIVE, active_port 0, target 0, switching 0, sel_error 0, switch_count 0, RSEQ clock reg 0; pass-through outputs follow port 0.
- Detection to ACTIVE: SETTLE_CYCLES + 2*RESET_TMS_CYCLES clk cycles after the sampling edge; switching rises on that edge's output, falls with the state entering ACTIVE.
- jtag_clk is never high on any DRAIN cycle; first RSEQ cycle drives jtag_clk=1.
- switch_count and active_port update on the same edge.
- rst_n asserted mid-switch: immediate return to reset values; no partial RSEQ resumes.

## Configuration
- JTAG_SWITCH_TRST_EN defined: jtag_rst_n=0 throughout DRAIN, 1 in RSEQ (hardware TRST plus TMS reset).
- Undefined: jtag_rst_n=1 in DRAIN and RSEQ; TAP reset relies on the TMS burst only.

## Test plan
- NUM_PORTS=3, SETTLE_CYCLES=4, RESET_TMS_CYCLES=5; port_sel 0->1 -> switching high 14 cycles, jtag_clk 0 for 4 then 5 pulses with TMS=1, active_port=1, switch_count=1.
- In ACTIVE on port 1: toggle port_tck[1]/tms/tdi, drive jtag_tdo=1 -> jtag_* follow port 1, port_tdo=3'b010; port 0/2 activity ignored.
- port_sel 0->1, then ->2 at DRAIN cycle 2 -> DRAIN restarts, completes 16 cycles after first detection, active_port=2, switch_count=1.
- port_sel=3 -> sel_error=1, no switch, active_port unchanged; stays 1 after port_sel returns to 0.
- rst_n low in RSEQ cycle 3 -> all outputs at reset values next observation, active_port=0, switch_count=0.
- With JTAG_SWITCH_TRST_EN: switch 0->2 -> jtag_rst_n=0 exactly the 4 DRAIN cycles; without: jtag_rst_n=1 throughout.
